instr_fetch: RTL and testbench

Instruction fetch unit that reads the 4096x12 read-only instruction memory. It sits between that memory and decode. It drives a PC-based read address every cycle and absorbs the memory's one-cycle synchronous read latency. It delivers {pc, instr} pairs to decode over a valid/ready handshake at up to one per cycle, and supports PC redirects with flush of in-flight fetches.

---
 rtl/instr_fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 89 ++++++++
 rtl/instr_fetch.sv | 90 +++++++++
 tb/tb_instr_fetch.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: widths and the {pc, instr} bundle
// handed from fetch to decode.
package instr_fetch_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 12;

  localparam logic [ADDR_W-1:0] RESET_PC = 12'h000;

  typedef logic [ADDR_W-1:0] pc_t;
  typedef logic [DATA_W-1:0] instr_t;

  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } fetch_entry_t;

  function automatic pc_t pc_inc(pc_t pc);
    return pc + pc_t'(1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetch entries
// with synchronous flush; head is read straight from storage.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  fetch_entry_t               wdata_i,
  output fetch_entry_t               head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full;
  logic             empty;

  function automatic logic [PTR_W-1:0] wrap_inc(
    logic [PTR_W-1:0] p
  );
    if (p == PTR_W'(DEPTH-1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wrap_inc(wr_q);
      if (pop_i)  rd_d = wrap_inc(rd_q);
      unique case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (push_i && !flush_i) begin
        mem_q[wr_q] <= wdata_i;
      end
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // The fetch credit check must keep these unreachable.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push_i && !pop_i && !flush_i && full)
  );

  a_no_underflow: assert property (
    @(posedge clk) disable iff (rst)
    !(pop_i && empty)
  );

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC sequencing over a 1-cycle synchronous imem,
// buffering {pc, instr} for decode with redirect/flush.
module instr_fetch #(
  parameter int DEPTH = 2,
  parameter logic [instr_fetch_pkg::ADDR_W-1:0] RESET_PC =
    instr_fetch_pkg::RESET_PC
) (
  input  logic                                clk,
  input  logic                                rst,
  output logic [instr_fetch_pkg::ADDR_W-1:0]  imem_addr,
  input  logic [instr_fetch_pkg::DATA_W-1:0]  imem_data,
  input  logic                                redirect_valid,
  input  logic [instr_fetch_pkg::ADDR_W-1:0]  redirect_pc,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [instr_fetch_pkg::DATA_W-1:0]  out_instr,
  output logic [instr_fetch_pkg::ADDR_W-1:0]  out_pc
);

  import instr_fetch_pkg::*;

  localparam int CNT_W = $clog2(DEPTH+1);

  pc_t              fetch_pc_q, fetch_pc_d;
  pc_t              dphase_pc_q, dphase_pc_d;
  logic             dphase_q, dphase_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   inflight;
  logic [CNT_W:0]   limit;
  logic             issue;
  logic             push;
  logic             pop;
  fetch_entry_t     wentry;
  fetch_entry_t     head;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = dphase_q & ~redirect_valid;

  // Credit: buffered + in-flight must fit once this cycle's pop leaves.
  assign inflight = {1'b0, count} + (CNT_W+1)'(dphase_q);
  assign limit    = (CNT_W+1)'(DEPTH) + (CNT_W+1)'(pop);
  assign issue    = ~redirect_valid & (inflight < limit);

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    dphase_pc_d = dphase_pc_q;
    dphase_d    = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d  = pc_inc(fetch_pc_q);
      dphase_pc_d = fetch_pc_q;
      dphase_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      dphase_pc_q <= '0;
      dphase_q    <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      dphase_pc_q <= dphase_pc_d;
      dphase_q    <= dphase_d;
    end
  end

  assign wentry.pc    = dphase_pc_q;
  assign wentry.instr = imem_data;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i (wentry),
    .head_o  (head),
    .count_o (count)
  );

  assign imem_addr = fetch_pc_q;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scoreboard bench for instr_fetch
// against a preloaded 4096x12 synchronous memory model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] imem_addr;
  logic [11:0] imem_data;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_instr;
  logic [11:0] out_pc;

  logic [11:0] mem [4096];
  logic [11:0] exp_q [$];

  int n_vec   = 0;
  int n_err   = 0;
  int n_deliv = 0;

  logic        held = 1'b0;
  logic [11:0] hpc, hins;
  logic [11:0] pc_e;

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 12'(i + 'h100);
  end

  always @(posedge clk) imem_data <= mem[imem_addr];

  instr_fetch #(
    .DEPTH    (2),
    .RESET_PC (12'h000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  function automatic logic [11:0] exp_instr(logic [11:0] pc);
    return pc + 12'h100;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(logic [11:0] start, int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 12'(i));
  endtask

  // Ends at the start of cycle 0 (first cycle with rst low).
  task automatic reset_seq();
    rst            = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 12'h000;
    exp_q.delete();
    tick();
    tick();
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_pc", 32'(out_pc), 0);
    chk("rst_instr", 32'(out_instr), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic end_phase(string name);
    out_ready = 1'b0;
    chk(name, 32'(exp_q.size()), 0);
  endtask

  // Scoreboard monitor: every handshake consumes the next expected pc.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held && out_valid) begin
          chk("stall_pc", 32'(out_pc), 32'(hpc));
          chk("stall_instr", 32'(out_instr), 32'(hins));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL extra_out: got pc %h, expected none", out_pc);
          end else begin
            pc_e = exp_q.pop_front();
            chk("out_pc", 32'(out_pc), 32'(pc_e));
            chk("out_instr", 32'(out_instr), 32'(exp_instr(pc_e)));
            n_deliv++;
          end
        end
        held = out_valid && !out_ready;
        hpc  = out_pc;
        hins = out_instr;
      end
    end
  end

  initial begin
    // Stream from reset, redirect to 7F0 in cycle 6.
    reset_seq();
    out_ready = 1'b1;
    push_run(12'h000, 5);
    push_run(12'h7F0, 3);
    @(negedge clk);
    chk("c0_valid", 32'(out_valid), 0);
    chk("c0_addr", 32'(imem_addr), 0);
    tick();
    @(negedge clk);
    chk("c1_valid", 32'(out_valid), 0);
    chk("c1_addr", 32'(imem_addr), 1);
    tick();
    @(negedge clk);
    chk("c2_valid", 32'(out_valid), 1);
    tick(); tick(); tick(); tick();
    redirect_valid = 1'b1;
    redirect_pc    = 12'h7F0;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("rd_n1_valid", 32'(out_valid), 0);
    chk("rd_n1_addr", 32'(imem_addr), 32'h7F0);
    tick();
    @(negedge clk);
    chk("rd_n2_valid", 32'(out_valid), 0);
    tick();
    @(negedge clk);
    chk("rd_n3_valid", 32'(out_valid), 1);
    chk("rd_n3_pc", 32'(out_pc), 32'h7F0);
    tick(); tick(); tick();
    end_phase("redir_drain");

    // Stall from cycle 2 for 5 cycles.
    reset_seq();
    out_ready = 1'b1;
    push_run(12'h000, 4);
    tick(); tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_hold_pc", 32'(out_pc), 0);
      chk("stall_hold_instr", 32'(out_instr), 32'h100);
      chk("stall_fetch_pc", 32'(imem_addr), 2);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", 32'(out_valid), 1);
    tick(); tick(); tick(); tick();
    end_phase("stall_drain");

    // Redirect to FFE and wrap.
    reset_seq();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 12'hFFE;
    exp_q.push_back(12'hFFE);
    exp_q.push_back(12'hFFF);
    exp_q.push_back(12'h000);
    exp_q.push_back(12'h001);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_addr1", 32'(imem_addr), 32'hFFE);
    chk("wrap_valid1", 32'(out_valid), 0);
    tick();
    @(negedge clk);
    chk("wrap_addr2", 32'(imem_addr), 32'hFFF);
    chk("wrap_valid2", 32'(out_valid), 0);
    tick();
    @(negedge clk);
    chk("wrap_addr3", 32'(imem_addr), 0);
    chk("wrap_valid3", 32'(out_valid), 1);
    tick(); tick(); tick(); tick();
    end_phase("wrap_drain");

    // Redirect with pop in cycle 3, second redirect in cycle 4.
    reset_seq();
    out_ready = 1'b1;
    push_run(12'h000, 2);
    push_run(12'h020, 2);
    tick(); tick(); tick();
    redirect_valid = 1'b1;
    redirect_pc    = 12'h010;
    tick();
    redirect_pc = 12'h020;
    @(negedge clk);
    chk("dbl_c4_valid", 32'(out_valid), 0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("dbl_c5_valid", 32'(out_valid), 0);
    chk("dbl_c5_addr", 32'(imem_addr), 32'h020);
    tick();
    @(negedge clk);
    chk("dbl_c6_valid", 32'(out_valid), 0);
    tick();
    @(negedge clk);
    chk("dbl_c7_pc", 32'(out_pc), 32'h020);
    tick(); tick();
    end_phase("dbl_drain");

    // Random ready with reset pulsed mid-stream.
    reset_seq();
    push_run(12'h000, 200);
    for (int k = 0; k < 40; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    rst       = 1'b1;
    out_ready = 1'b0;
    exp_q.delete();
    tick();
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 0);
    chk("post_rst_addr", 32'(imem_addr), 0);
    n_deliv = 0;
    push_run(12'h000, 200);
    for (int k = 0; k < 60; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b0;
    chk("rand_progress", 32'(n_deliv >= 10), 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
